// File: rtl/pwm_duty_slew.sv
// Slew-rate limiter from the SPI duty register to the PWM duty input: one STEP per TICK_DIV clocks.
// Optional done pulse output is enabled with `define PWM_DUTY_SLEW_DONE_EN.
module pwm_duty_slew #(
    parameter logic [15:0] STEP     = 16'd1,
    parameter logic [15:0] TICK_DIV = 16'd3333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bypass,
    input  logic [7:0] target_duty,
    output logic [7:0] duty_out,
`ifdef PWM_DUTY_SLEW_DONE_EN
    output logic       done,
`endif
    output logic       busy
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] target_q, target_q_n;
    logic [DW-1:0] duty_n;
    logic          done_q, done_n;
    logic          tick;
    logic [DW:0]   up_sum;
    logic signed [DW:0] dn_diff;
    logic [DW-1:0] up_val, dn_val;

    assign tick = (cnt == (TICK_DIV - 16'd1));

    // Candidate step results, clamped at the target so a step never overshoots
    assign up_sum  = {1'b0, duty_out} + (DW+1)'(STEP);
    assign dn_diff = $signed({1'b0, duty_out}) - $signed((DW+1)'(STEP));
    assign up_val  = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DW-1:0];
    assign dn_val  = (dn_diff < $signed({1'b0, target_q})) ? target_q : dn_diff[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            target_q <= '0;
            duty_out <= '0;
            busy     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            target_q <= target_q_n;
            duty_out <= duty_n;
            busy     <= (state_n != IDLE);
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        target_q_n = target_q;
        duty_n     = duty_out;
        done_n     = 1'b0;
        if (bypass) begin
            duty_n     = target_q;
            target_q_n = target_duty;
            state_n    = IDLE;
            cnt_n      = '0;
        end else if (ena) begin
            target_q_n = target_duty;
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (target_q > duty_out) begin
                        state_n = UP;
                    end else if (target_q < duty_out) begin
                        state_n = DOWN;
                    end
                end
                UP, DOWN: begin
                    cnt_n = tick ? '0 : cnt + 16'd1;
                    if (target_q == duty_out) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else if ((state == UP) && (target_q < duty_out)) begin
                        state_n = DOWN;
                    end else if ((state == DOWN) && (target_q > duty_out)) begin
                        state_n = UP;
                    end else if (tick) begin
                        duty_n = (state == UP) ? up_val : dn_val;
                        if (duty_n == target_q) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef PWM_DUTY_SLEW_DONE_EN
    assign done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Scoreboard bench for pwm_duty_slew: a driver advances a behavioural model and queues the
// expected outputs for each clock; a monitor pops and compares them after every rising edge.
module tb_pwm_duty_slew;
    localparam int ST = 16;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] target_duty = 8'h00;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    pwm_duty_slew #(.STEP(16'(ST)), .TICK_DIV(16'(TD))) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .bypass     (bypass),
        .target_duty(target_duty),
        .duty_out   (duty_out),
`ifdef PWM_DUTY_SLEW_DONE_EN
        .done       (done),
`endif
        .busy       (busy)
    );
`ifndef PWM_DUTY_SLEW_DONE_EN
    assign done = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    // Reference: "moving" toward the target, with a countdown of clocks left until the next step
    int m_tq = 0, m_duty = 0, m_left = 0;
    bit m_mv = 0, m_up = 0, m_done = 0;

    task automatic model(input bit r, input bit e, input bit b, input int t);
        if (!r) begin
            m_tq = 0; m_duty = 0; m_mv = 0; m_left = 0; m_done = 0;
        end else if (b) begin
            m_done = 0; m_duty = m_tq; m_tq = t; m_mv = 0;
        end else if (e) begin
            m_done = 0;
            if (!m_mv) begin
                if (m_tq != m_duty) begin
                    m_mv = 1; m_up = (m_tq > m_duty); m_left = TD;
                end
            end else if (m_tq == m_duty) begin
                m_mv = 0; m_done = 1;
            end else begin
                m_left = m_left - 1;
                if ((m_up && m_tq < m_duty) || (!m_up && m_tq > m_duty)) begin
                    m_up = !m_up;
                    if (m_left == 0) m_left = TD;
                end else if (m_left == 0) begin
                    m_left = TD;
                    if (m_up) m_duty = (m_duty + ST > m_tq) ? m_tq : m_duty + ST;
                    else      m_duty = (m_duty - ST < m_tq) ? m_tq : m_duty - ST;
                    if (m_duty == m_tq) begin
                        m_mv = 0; m_done = 1;
                    end
                end
            end
            m_tq = t;
        end else begin
            m_done = 0;
        end
    endtask

    // Drive one clock of stimulus and queue what the DUT must show after the next rising edge
    task automatic cyc(input bit r, input bit e, input bit b, input int t);
        exp_t x;
        @(negedge clk);
        rst_n = r; ena = e; bypass = b; target_duty = 8'(t);
        model(r, e, b, t);
        x.duty = 8'(m_duty); x.busy = m_mv; x.done = m_done;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input bit r, input bit e, input bit b, input int t);
        for (int i = 0; i < n; i++) cyc(r, e, b, t);
    endtask

    task automatic ramp_until(input int t, input int stop_at);
        for (int i = 0; i < 200 && m_duty != stop_at; i++) cyc(1, 1, 0, t);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if (duty_out !== x.duty || busy !== x.busy) begin
                    n_fail++;
                    $display("FAIL out @%0t: duty_out=%h busy=%b, required duty_out=%h busy=%b",
                             $time, duty_out, busy, x.duty, x.busy);
                end
`ifdef PWM_DUTY_SLEW_DONE_EN
                n_checks++;
                if (done !== x.done) begin
                    n_fail++;
                    $display("FAIL done @%0t: got %b, required %b", $time, done, x.done);
                end
                if (done === 1'b1) n_done++;
`endif
            end
        end
    end

    initial begin : driver
        int t;
        bit b, e, r;
        // reset with a nonzero target, then release while disabled
        run(3, 0, 0, 0, 8'hAA);
        run(5, 1, 0, 0, 8'hAA);
        // basic ramp 0x00 -> 0x40
        run(3, 1, 1, 0, 8'h00);
        n_done = 0;
        run(25, 1, 1, 0, 8'h40);
`ifdef PWM_DUTY_SLEW_DONE_EN
        @(negedge clk);
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d pulses, required 1", n_done);
        end
`endif
        // bypass jump high, then slew to the top without wrapping
        n_done = 0;
        run(3, 1, 1, 1, 8'hF8);
`ifdef PWM_DUTY_SLEW_DONE_EN
        @(negedge clk);
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL bypass_done: got %0d pulses, required 0", n_done);
        end
`endif
        run(10, 1, 1, 0, 8'hFF);
        run(3, 1, 1, 1, 8'h05);
        run(10, 1, 1, 0, 8'h00);
        // reversal mid-ramp
        ramp_until(8'h80, 8'h30);
        run(20, 1, 1, 0, 8'h10);
        // freeze mid-ramp, resume, then reset mid-ramp
        run(3, 1, 1, 0, 8'h00);
        ramp_until(8'h00, 8'h00);
        ramp_until(8'h80, 8'h20);
        run(20, 1, 0, 0, 8'h80);
        run(6, 1, 1, 0, 8'h80);
        run(2, 0, 1, 0, 8'h80);
        run(4, 1, 1, 0, 8'h80);
        // random traffic
        t = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) t = int'($urandom_range(0, 255));
            e = ($urandom_range(0, 7) != 0);
            b = ($urandom_range(0, 40) == 0);
            r = ($urandom_range(0, 300) != 0);
            cyc(r, e, b, t);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
